rf_capture_sequencer: RTL and testbench

Control-domain sequencer that runs a DAC-playback / ADC-capture loop as one coordinated measurement. It resets both datapaths, starts DAC playback, waits a programmed delay, starts ADC capture to PS DDR, waits for capture-done (with timeout), and repeats for a programmed iteration count. It sits between the register map and the DAC/ADC data paths in the AXI-Lite clock domain, replacing direct software writes of the start/reset bits, and raises a single-cycle interrupt on completion or error.

---
 rtl/rf_capture_sequencer.sv | 264 ++++++++++++++++++++++++++
 tb/tb_rf_capture_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_capture_sequencer.sv
// rf_capture_sequencer
// Runs a DAC-playback / ADC-capture measurement loop: resets both datapaths,
// starts DAC playback, waits a programmed delay, starts ADC capture, waits for
// capture-done (optionally bounded by a timeout) and repeats for a programmed
// number of iterations. Raises a one-cycle irq when a run ends, whether it
// completed or stopped on an error.
// All outputs are registered. Each one is computed from the next state, so it
// changes on the same edge as the state it belongs to.

module rf_capture_sequencer #(
  parameter int RESET_CYCLES = 16,
  parameter int ITER_W       = 16
) (
  input  logic              axilite_clk,
  input  logic              axilite_rst,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ITER_W-1:0] cfg_iterations,
  input  logic [31:0]       cfg_adc_delay,
  input  logic [31:0]       cfg_timeout,
  input  logic [31:0]       cfg_gap,
  input  logic              adc_cap_done,
  input  logic              adc_err,
  output logic              dac_reset,
  output logic              adc_reset,
  output logic              dac_start,
  output logic              adc_start,
  output logic              busy,
  output logic              done,
  output logic              timeout_err,
  output logic              cap_err,
  output logic              aborted,
  output logic [ITER_W-1:0] iter_count,
  output logic              irq
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST,
    S_DAC_GO,
    S_DELAY,
    S_ADC_GO,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH,
    S_ERR
  } state_e;

  // Length of one datapath reset phase. In ERR the counter runs one step
  // further: the value RST_LEN marks the irq cycle.
  localparam logic [31:0] RST_LEN = 32'(RESET_CYCLES);
  localparam logic [ITER_W-1:0] ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       cnt_inc;
  logic [ITER_W-1:0] iters_q, iters_d;
  logic [31:0]       delay_q, delay_d;
  logic [31:0]       timeout_q, timeout_d;
  logic [31:0]       gap_q, gap_d;
  logic [ITER_W-1:0] iter_cnt_q, iter_cnt_d;
  logic [ITER_W-1:0] iter_inc;
  logic              done_q, done_d;
  logic              terr_q, terr_d;
  logic              cerr_q, cerr_d;
  logic              abrt_q, abrt_d;
  logic              rst_req_q, rst_req_d;
  logic              dac_go_q, dac_go_d;
  logic              adc_go_q, adc_go_d;
  logic              busy_q, busy_d;
  logic              irq_q, irq_d;
  logic              abort_hit;

  assign cnt_inc  = cnt_q + 32'd1;
  assign iter_inc = iter_cnt_q + ITER_ONE;

  // Abort is honoured only while a run is in progress and not already ending
  assign abort_hit = cfg_abort && (state_q != S_IDLE) &&
                     (state_q != S_FINISH) && (state_q != S_ERR);

  // Next-state, phase counter, latched configuration and sticky flags
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iters_d    = iters_q;
    delay_d    = delay_q;
    timeout_d  = timeout_q;
    gap_d      = gap_q;
    iter_cnt_d = iter_cnt_q;
    done_d     = done_q;
    terr_d     = terr_q;
    cerr_d     = cerr_q;
    abrt_d     = abrt_q;

    if (abort_hit) begin
      state_d = S_ERR;
      cnt_d   = 32'd0;
      abrt_d  = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          // Abort in the same cycle suppresses the start
          if (cfg_start && !cfg_abort) begin
            state_d    = S_RST;
            cnt_d      = 32'd0;
            iters_d    = (cfg_iterations == '0) ? ITER_ONE : cfg_iterations;
            delay_d    = cfg_adc_delay;
            timeout_d  = cfg_timeout;
            gap_d      = cfg_gap;
            iter_cnt_d = '0;
            done_d     = 1'b0;
            terr_d     = 1'b0;
            cerr_d     = 1'b0;
            abrt_d     = 1'b0;
          end
        end

        S_RST: begin
          if (cnt_inc == RST_LEN) begin
            state_d = S_DAC_GO;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_DAC_GO: begin
          cnt_d   = 32'd0;
          state_d = (delay_q != 32'd0) ? S_DELAY : S_ADC_GO;
        end

        S_DELAY: begin
          if (cnt_inc == delay_q) begin
            state_d = S_ADC_GO;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_ADC_GO: begin
          state_d = S_WAIT_DONE;
          cnt_d   = 32'd0;
        end

        S_WAIT_DONE: begin
          // Priority: write-path error, then capture-done, then timeout
          if (adc_err) begin
            state_d = S_ERR;
            cnt_d   = 32'd0;
            cerr_d  = 1'b1;
          end else if (adc_cap_done) begin
            iter_cnt_d = iter_inc;
            cnt_d      = 32'd0;
            if (iter_inc == iters_q) begin
              state_d = S_FINISH;
              done_d  = 1'b1;
            end else if (gap_q != 32'd0) begin
              state_d = S_GAP;
            end else begin
              state_d = S_RST;
            end
          end else if ((timeout_q != 32'd0) && (cnt_inc == timeout_q)) begin
            state_d = S_ERR;
            cnt_d   = 32'd0;
            terr_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_GAP: begin
          if (cnt_inc == gap_q) begin
            state_d = S_RST;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        S_FINISH: begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end

        S_ERR: begin
          // Counts 0..RST_LEN-1 with resets held, then one irq cycle at RST_LEN
          if (cnt_q == RST_LEN) begin
            state_d = S_IDLE;
            cnt_d   = 32'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end

        default: begin
          state_d = S_IDLE;
          cnt_d   = 32'd0;
        end
      endcase
    end
  end

  // Output register inputs derived from the state being entered
  always_comb begin
    rst_req_d = (state_d == S_RST) || ((state_d == S_ERR) && (cnt_d != RST_LEN));
    dac_go_d  = (state_d == S_DAC_GO);
    adc_go_d  = (state_d == S_ADC_GO);
    busy_d    = (state_d != S_IDLE);
    irq_d     = (state_d == S_FINISH) || ((state_d == S_ERR) && (cnt_d == RST_LEN));
  end

  // State, counters, configuration, flags and output registers
  always_ff @(posedge axilite_clk or posedge axilite_rst) begin
    if (axilite_rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 32'd0;
      iters_q    <= '0;
      delay_q    <= 32'd0;
      timeout_q  <= 32'd0;
      gap_q      <= 32'd0;
      iter_cnt_q <= '0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
      cerr_q     <= 1'b0;
      abrt_q     <= 1'b0;
      rst_req_q  <= 1'b0;
      dac_go_q   <= 1'b0;
      adc_go_q   <= 1'b0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      iters_q    <= iters_d;
      delay_q    <= delay_d;
      timeout_q  <= timeout_d;
      gap_q      <= gap_d;
      iter_cnt_q <= iter_cnt_d;
      done_q     <= done_d;
      terr_q     <= terr_d;
      cerr_q     <= cerr_d;
      abrt_q     <= abrt_d;
      rst_req_q  <= rst_req_d;
      dac_go_q   <= dac_go_d;
      adc_go_q   <= adc_go_d;
      busy_q     <= busy_d;
      irq_q      <= irq_d;
    end
  end

  assign dac_reset   = rst_req_q;
  assign adc_reset   = rst_req_q;
  assign dac_start   = dac_go_q;
  assign adc_start   = adc_go_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign cap_err     = cerr_q;
  assign aborted     = abrt_q;
  assign iter_count  = iter_cnt_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_rf_capture_sequencer.sv
// Testbench for rf_capture_sequencer: drives measurement runs, emulates the
// ADC capture-done/err behaviour and checks event timing against cycle
// arithmetic derived from the sequencing rules.

module tb_rf_capture_sequencer;

  localparam int R  = 16;
  localparam int IW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_start = 1'b0;
  logic          cfg_abort = 1'b0;
  logic [IW-1:0] cfg_iterations = '0;
  logic [31:0]   cfg_adc_delay = '0;
  logic [31:0]   cfg_timeout = '0;
  logic [31:0]   cfg_gap = '0;
  logic          adc_cap_done = 1'b0;
  logic          adc_err = 1'b0;
  logic          dac_reset, adc_reset, dac_start, adc_start, busy, done;
  logic          timeout_err, cap_err, aborted, irq;
  logic [IW-1:0] iter_count;

  rf_capture_sequencer #(.RESET_CYCLES(R), .ITER_W(IW)) dut (
    .axilite_clk   (clk),
    .axilite_rst   (rst),
    .cfg_start     (cfg_start),
    .cfg_abort     (cfg_abort),
    .cfg_iterations(cfg_iterations),
    .cfg_adc_delay (cfg_adc_delay),
    .cfg_timeout   (cfg_timeout),
    .cfg_gap       (cfg_gap),
    .adc_cap_done  (adc_cap_done),
    .adc_err       (adc_err),
    .dac_reset     (dac_reset),
    .adc_reset     (adc_reset),
    .dac_start     (dac_start),
    .adc_start     (adc_start),
    .busy          (busy),
    .done          (done),
    .timeout_err   (timeout_err),
    .cap_err       (cap_err),
    .aborted       (aborted),
    .iter_count    (iter_count),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Cycle numbering: an input driven after negedge while now==c is sampled at
  // edge c; an output seen while now==c was registered at edge c-1.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int dac_q[$];
  int adc_q[$];
  int irq_q[$];
  int rst_cycles   = 0;
  int rst_mismatch = 0;
  int terr_at      = -1;
  int lat          = 0;
  bit err_mode     = 1'b0;
  int cap_at       = -1;
  bit prev_terr    = 1'b0;

  // Event monitor plus ADC model: capture-done rises lat cycles after
  // adc_start (0 = never), optionally with adc_err, and clears on adc_reset.
  always @(negedge clk) begin
    int now_c;
    now_c = cyc + 1;
    if (dac_start) dac_q.push_back(now_c);
    if (adc_start) begin
      adc_q.push_back(now_c);
      cap_at = (lat > 0) ? now_c + lat : -1;
    end
    if (irq) irq_q.push_back(now_c);
    if (dac_reset && adc_reset) rst_cycles++;
    if (dac_reset !== adc_reset) rst_mismatch++;
    if (timeout_err && !prev_terr) terr_at = now_c;
    prev_terr = timeout_err;
    if (adc_reset) begin
      adc_cap_done = 1'b0;
      adc_err      = 1'b0;
    end else if (now_c == cap_at) begin
      adc_cap_done = 1'b1;
      if (err_mode) adc_err = 1'b1;
    end
  end

  task automatic launch(input int n, input int d, input int t, input int g,
                        input int l, input bit em, output int k);
    @(negedge clk);
    dac_q.delete();
    adc_q.delete();
    irq_q.delete();
    rst_cycles     = 0;
    rst_mismatch   = 0;
    terr_at        = -1;
    lat            = l;
    err_mode       = em;
    cfg_iterations = IW'(n);
    cfg_adc_delay  = d;
    cfg_timeout    = t;
    cfg_gap        = g;
    cfg_start      = 1'b1;
    k = cyc + 1;
    @(negedge clk);
    cfg_start = 1'b0;
    // Configuration must be latched at start; scramble it afterwards
    cfg_iterations = IW'($urandom);
    cfg_adc_delay  = $urandom;
    cfg_timeout    = $urandom_range(1, 3);
    cfg_gap        = $urandom;
  endtask

  task automatic wait_idle(input int budget, output bit ok, output int at);
    ok = 1'b0;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        at = cyc + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++;
    if ({dac_reset, adc_reset, dac_start, adc_start} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {dac_reset, adc_reset, dac_start, adc_start});
    end
    n_checks++;
    if ({done, timeout_err, cap_err, aborted, irq} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00000", {done, timeout_err, cap_err, aborted, irq});
    end
    n_checks++;
    if (iter_count !== '0) begin n_fail++; $display("FAIL reset_iter: got %0d want 0", iter_count); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, dac_reset, irq, done} !== 4'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b want 0000", {busy, dac_reset, irq, done});
    end
    $display("test_reset: done");
  endtask

  task automatic test_single();
    int k, at;
    bit ok;
    launch(1, 10, 0, 0, 50, 1'b0, k);
    wait_idle(2000, ok, at);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL single_wait: got busy want idle"); end
    n_checks++;
    if (dac_q.size() != 1 || dac_q[0] != k + 17) begin
      n_fail++; $display("FAIL single_dac: got n=%0d t=%0d want t=%0d", dac_q.size(), (dac_q.size() > 0) ? dac_q[0] - k : -1, 17);
    end
    n_checks++;
    if (adc_q.size() != 1 || adc_q[0] != k + 28) begin
      n_fail++; $display("FAIL single_adc: got n=%0d t=%0d want t=%0d", adc_q.size(), (adc_q.size() > 0) ? adc_q[0] - k : -1, 28);
    end
    n_checks++;
    if (irq_q.size() != 1 || irq_q[0] != k + 28 + 51) begin
      n_fail++; $display("FAIL single_irq: got n=%0d t=%0d want n=1 t=%0d", irq_q.size(), (irq_q.size() > 0) ? irq_q[0] - k : -1, 79);
    end
    n_checks++;
    if (at != k + 80) begin n_fail++; $display("FAIL single_idle: got %0d want %0d", at - k, 80); end
    n_checks++;
    if (done !== 1'b1 || iter_count !== 16'd1) begin
      n_fail++; $display("FAIL single_done: got done=%b iter=%0d want 1/1", done, iter_count);
    end
    n_checks++;
    if (rst_cycles != R || rst_mismatch != 0) begin
      n_fail++; $display("FAIL single_resets: got %0d/%0d want %0d/0", rst_cycles, rst_mismatch, R);
    end
    $display("test_single: k=%0d dac=%0d adc=%0d", k, (dac_q.size() > 0) ? dac_q[0] : -1, (adc_q.size() > 0) ? adc_q[0] : -1);
  endtask

  // Several runs with random configuration, one of them the fixed
  // three-iteration/gap-5/no-delay case, checked against cycle arithmetic.
  task automatic test_iterations();
    for (int r = 0; r < 8; r++) begin
      int n, d, g, l, t, neff, k, at, tr, m, e_irq;
      bit ok;
      int e_dac[$];
      int e_adc[$];
      if (r == 0) begin
        n = 3; d = 0; g = 5; l = 7; t = 0;
      end else begin
        n = $urandom_range(0, 4);
        d = $urandom_range(0, 6);
        g = $urandom_range(0, 6);
        l = $urandom_range(1, 12);
        t = ($urandom_range(0, 1) == 1) ? 0 : l + $urandom_range(0, 3);
      end
      neff = (n == 0) ? 1 : n;
      launch(n, d, t, g, l, 1'b0, k);
      wait_idle(5000, ok, at);
      // Reference timeline: resets start one cycle after tr
      tr = k;
      m  = 0;
      for (int i = 0; i < neff; i++) begin
        e_dac.push_back(tr + R + 1);
        e_adc.push_back(tr + R + 2 + d);
        m  = tr + R + 2 + d + l;
        tr = m + g;
      end
      e_irq = m + 1;
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL iter_wait run %0d: got busy want idle", r); end
      n_checks++;
      if (dac_q.size() != neff || adc_q.size() != neff) begin
        n_fail++; $display("FAIL iter_count_starts run %0d: got %0d/%0d want %0d", r, dac_q.size(), adc_q.size(), neff);
      end
      for (int i = 0; i < neff; i++) begin
        int gd, ga;
        gd = (i < dac_q.size()) ? dac_q[i] : -1;
        ga = (i < adc_q.size()) ? adc_q[i] : -1;
        n_checks++;
        if (gd != e_dac[i] || ga != e_adc[i]) begin
          n_fail++; $display("FAIL iter_timing run %0d it %0d: got dac=%0d adc=%0d want dac=%0d adc=%0d", r, i, gd, ga, e_dac[i], e_adc[i]);
        end
      end
      n_checks++;
      if (irq_q.size() != 1 || irq_q[0] != e_irq || at != e_irq + 1) begin
        n_fail++; $display("FAIL iter_irq run %0d: got n=%0d t=%0d idle=%0d want t=%0d idle=%0d", r, irq_q.size(), (irq_q.size() > 0) ? irq_q[0] : -1, at, e_irq, e_irq + 1);
      end
      n_checks++;
      if (done !== 1'b1 || iter_count !== IW'(neff) || {timeout_err, cap_err, aborted} !== 3'b0) begin
        n_fail++; $display("FAIL iter_status run %0d: got done=%b iter=%0d flags=%b want 1/%0d/000", r, done, iter_count, {timeout_err, cap_err, aborted}, neff);
      end
      n_checks++;
      if (rst_cycles != neff * R || rst_mismatch != 0) begin
        n_fail++; $display("FAIL iter_resets run %0d: got %0d/%0d want %0d/0", r, rst_cycles, rst_mismatch, neff * R);
      end
      $display("test_iterations: run %0d n=%0d d=%0d g=%0d l=%0d t=%0d irq_at=%0d", r, n, d, g, l, t, e_irq - k);
    end
  endtask

  task automatic test_timeout();
    int k, at, a;
    bit ok;
    launch(2, 3, 100, 0, 0, 1'b0, k);
    wait_idle(2000, ok, at);
    a = (adc_q.size() > 0) ? adc_q[0] : -1000;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL timeout_wait: got busy want idle"); end
    n_checks++;
    if (a != k + 21) begin n_fail++; $display("FAIL timeout_adc: got %0d want %0d", a - k, 21); end
    n_checks++;
    if (terr_at != a + 101) begin n_fail++; $display("FAIL timeout_flag_time: got %0d want %0d", terr_at - a, 101); end
    n_checks++;
    if (irq_q.size() != 1 || irq_q[0] != a + 101 + R) begin
      n_fail++; $display("FAIL timeout_irq: got n=%0d t=%0d want t=%0d", irq_q.size(), (irq_q.size() > 0) ? irq_q[0] - a : -1, 101 + R);
    end
    n_checks++;
    if (rst_cycles != 2 * R) begin n_fail++; $display("FAIL timeout_resets: got %0d want %0d", rst_cycles, 2 * R); end
    n_checks++;
    if ({timeout_err, done, cap_err, aborted} !== 4'b1000 || iter_count !== '0) begin
      n_fail++; $display("FAIL timeout_status: got flags=%b iter=%0d want 1000/0", {timeout_err, done, cap_err, aborted}, iter_count);
    end
    $display("test_timeout: flag at adc+%0d", terr_at - a);
  endtask

  task automatic test_abort();
    int k, at;
    bit ok;
    launch(1, 40, 0, 0, 5, 1'b0, k);
    repeat (24) @(negedge clk);
    cfg_abort = 1'b1;  // sampled at edge k+25, inside the delay phase
    @(negedge clk);
    cfg_abort = 1'b0;
    wait_idle(2000, ok, at);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL abort_wait: got busy want idle"); end
    n_checks++;
    if (adc_q.size() != 0 || dac_q.size() != 1) begin
      n_fail++; $display("FAIL abort_starts: got dac=%0d adc=%0d want 1/0", dac_q.size(), adc_q.size());
    end
    n_checks++;
    if (irq_q.size() != 1 || irq_q[0] != k + 25 + 1 + R) begin
      n_fail++; $display("FAIL abort_irq: got n=%0d t=%0d want t=%0d", irq_q.size(), (irq_q.size() > 0) ? irq_q[0] - k : -1, 26 + R);
    end
    n_checks++;
    if ({aborted, done, timeout_err, cap_err} !== 4'b1000 || iter_count !== '0) begin
      n_fail++; $display("FAIL abort_status: got flags=%b iter=%0d want 1000/0", {aborted, done, timeout_err, cap_err}, iter_count);
    end
    n_checks++;
    if (rst_cycles != 2 * R) begin n_fail++; $display("FAIL abort_resets: got %0d want %0d", rst_cycles, 2 * R); end
    $display("test_abort: irq at k+%0d", (irq_q.size() > 0) ? irq_q[0] - k : -1);
  endtask

  task automatic test_cap_err();
    int k, at, a;
    bit ok;
    launch(2, 3, 0, 0, 6, 1'b1, k);
    wait_idle(2000, ok, at);
    err_mode = 1'b0;
    a = (adc_q.size() > 0) ? adc_q[0] : -1000;
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL caperr_wait: got busy want idle"); end
    n_checks++;
    if (irq_q.size() != 1 || irq_q[0] != a + 6 + 1 + R) begin
      n_fail++; $display("FAIL caperr_irq: got n=%0d t=%0d want t=%0d", irq_q.size(), (irq_q.size() > 0) ? irq_q[0] - a : -1, 7 + R);
    end
    n_checks++;
    if ({cap_err, done, timeout_err, aborted} !== 4'b1000 || iter_count !== '0) begin
      n_fail++; $display("FAIL caperr_status: got flags=%b iter=%0d want 1000/0", {cap_err, done, timeout_err, aborted}, iter_count);
    end
    n_checks++;
    if (adc_q.size() != 1) begin n_fail++; $display("FAIL caperr_starts: got %0d want 1", adc_q.size()); end
    $display("test_cap_err: irq at adc+%0d", (irq_q.size() > 0) ? irq_q[0] - a : -1);
  endtask

  task automatic test_ignored_requests();
    int k, at;
    bit ok, busy_seen;
    launch(1, 30, 0, 0, 5, 1'b0, k);
    repeat (9) @(negedge clk);
    cfg_start = 1'b1;  // during the reset phase
    @(negedge clk);
    cfg_start = 1'b0;
    repeat (29) @(negedge clk);
    cfg_start = 1'b1;  // during the delay phase
    @(negedge clk);
    cfg_start = 1'b0;
    wait_idle(2000, ok, at);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL busystart_wait: got busy want idle"); end
    n_checks++;
    if (dac_q.size() != 1 || adc_q.size() != 1 || adc_q[0] != k + 48) begin
      n_fail++; $display("FAIL busystart_timing: got dac=%0d adc=%0d t=%0d want 1/1 t=48", dac_q.size(), adc_q.size(), (adc_q.size() > 0) ? adc_q[0] - k : -1);
    end
    n_checks++;
    if (irq_q.size() != 1 || done !== 1'b1 || iter_count !== 16'd1) begin
      n_fail++; $display("FAIL busystart_status: got irq=%0d done=%b iter=%0d want 1/1/1", irq_q.size(), done, iter_count);
    end
    // Start together with abort while idle must not launch anything
    rst_cycles = 0;
    irq_q.delete();
    @(negedge clk);
    cfg_start = 1'b1;
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    n_checks++;
    if (busy_seen || rst_cycles != 0 || irq_q.size() != 0) begin
      n_fail++; $display("FAIL idle_startabort: got busy=%b resets=%0d irq=%0d want 0/0/0", busy_seen, rst_cycles, irq_q.size());
    end
    n_checks++;
    if (done !== 1'b1 || aborted !== 1'b0 || iter_count !== 16'd1) begin
      n_fail++; $display("FAIL idle_state_kept: got done=%b aborted=%b iter=%0d want 1/0/1", done, aborted, iter_count);
    end
    $display("test_ignored_requests: done");
  endtask

  task automatic test_async_reset();
    int k, at;
    bit ok;
    launch(2, 2, 0, 0, 40, 1'b0, k);
    repeat (29) @(negedge clk);  // now k+30, waiting for capture-done
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL arst_pre_busy: got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({dac_reset, adc_reset, dac_start, adc_start, busy, done, timeout_err, cap_err, aborted, irq} !== 10'b0 || iter_count !== '0) begin
      n_fail++; $display("FAIL arst_outputs: got %b iter=%0d want 0", {dac_reset, adc_reset, dac_start, adc_start, busy, done, timeout_err, cap_err, aborted, irq}, iter_count);
    end
    irq_q.delete();
    repeat (3) @(negedge clk);
    cap_at = -1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (irq_q.size() != 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL arst_quiet: got irq=%0d busy=%b want 0/0", irq_q.size(), busy);
    end
    launch(1, 4, 0, 0, 8, 1'b0, k);
    wait_idle(2000, ok, at);
    n_checks++;
    if (!ok || irq_q.size() != 1 || irq_q[0] != k + R + 6 + 8 + 1) begin
      n_fail++; $display("FAIL arst_rerun_irq: got ok=%b n=%0d t=%0d want t=%0d", ok, irq_q.size(), (irq_q.size() > 0) ? irq_q[0] - k : -1, R + 15);
    end
    n_checks++;
    if (done !== 1'b1 || iter_count !== 16'd1) begin
      n_fail++; $display("FAIL arst_rerun_status: got done=%b iter=%0d want 1/1", done, iter_count);
    end
    $display("test_async_reset: done");
  endtask

  initial begin
    test_reset();
    test_single();
    test_iterations();
    test_timeout();
    test_abort();
    test_cap_err();
    test_ignored_requests();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
